// File: rtl/ifetch_pkg.sv
// Shared types and constants for the lab5 instruction fetch controller.
package ifetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] PC_STEP  = 8'd2;
  localparam logic [ADDR_W-1:0] LAST_PC  = 8'hFE;
  localparam logic [15:0]       FCNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry synchronous FIFO of {pc, instr}; head reads as zero when empty.
module ifetch_fifo2
  import ifetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     data_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] count_q;
  logic       pop_ok_s;
  logic       push_ok_s;

  // Guard against popping empty / pushing full so pointers never desync.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != 2'd0);
    push_ok_s = push_i && ((count_q != 2'd2) || pop_ok_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok_s) begin
        rd_q <= ~rd_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = (count_q != 2'd0) ? mem_q[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the PC, run/stop/halt FSM, redirect handling and
// the saturating fetch counter; buffered instructions leave via ifetch_fifo2.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RUN,
  input  logic               REDIRECT,
  input  logic [ADDR_W-1:0]  REDIRECT_PC,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_Q,
  output logic [INSTR_W-1:0] INSTR,
  output logic [ADDR_W-1:0]  INSTR_PC,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
  output logic               HALTED,
  output logic [15:0]        FETCH_COUNT
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              halted_q;
  logic              fetch_s;
  logic              pop_s;
  logic [1:0]        count_s;
  logic [ADDR_W-1:0] target_s;
  entry_t            push_entry_s;
  entry_t            head_s;

  always_comb begin
    target_s     = REDIRECT_PC & 8'hFE;
    fetch_s      = (state_q == ST_FETCH) && RUN && !REDIRECT && (count_s != 2'd2);
    pop_s        = INSTR_VALID && INSTR_READY;
    push_entry_s = '{pc: pc_q, instr: IMEM_Q};
    state_d      = state_q;
    pc_d         = pc_q;
    fcnt_d       = fcnt_q;
    // A redirect overrides all other transitions and only leaves HALT.
    if (REDIRECT) begin
      pc_d = target_s;
      if (state_q == ST_HALT) begin
        state_d = ST_FETCH;
      end else begin
        state_d = state_q;
      end
    end else begin
      if (fetch_s) begin
        pc_d   = pc_q + PC_STEP;
        fcnt_d = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + 16'd1;
      end else begin
        pc_d   = pc_q;
        fcnt_d = fcnt_q;
      end
      case (state_q)
        ST_IDLE:  state_d = RUN ? ST_FETCH : ST_IDLE;
        ST_FETCH: begin
          if (fetch_s && (pc_q == LAST_PC)) begin
            state_d = ST_HALT;
          end else if (!RUN) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC & 8'hFE;
      fcnt_q   <= 16'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fcnt_q   <= fcnt_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  ifetch_fifo2 u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (fetch_s),
    .pop_i   (pop_s),
    .flush_i (REDIRECT),
    .data_i  (push_entry_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign IMEM_ADDR   = pc_q;
  assign INSTR       = head_s.instr;
  assign INSTR_PC    = head_s.pc;
  assign INSTR_VALID = (count_s != 2'd0);
  assign HALTED      = halted_q;
  assign FETCH_COUNT = fcnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_ifetch_ctrl;

  logic        CLK;
  logic        RESET;
  logic        RUN;
  logic        REDIRECT;
  logic [7:0]  REDIRECT_PC;
  logic [7:0]  IMEM_ADDR;
  logic [15:0] IMEM_Q;
  logic [15:0] INSTR;
  logic [7:0]  INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        HALTED;
  logic [15:0] FETCH_COUNT;

  logic [15:0] mem [128];
  assign IMEM_Q = mem[IMEM_ADDR[7:1]];

  ifetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IMEM_ADDR(IMEM_ADDR), .IMEM_Q(IMEM_Q),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .HALTED(HALTED), .FETCH_COUNT(FETCH_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] m_buf [$];
  logic [7:0]  m_pc;
  int          m_cnt;
  int          m_state;
  logic [49:0] act;
  logic [15:0] saved;

  function automatic logic [49:0] exp_out();
    logic [23:0] h;
    h = (m_buf.size() > 0) ? m_buf[0] : 24'h0;
    return {(m_buf.size() > 0), h[23:16], h[15:0], m_pc, (m_state == M_HALT), m_cnt[15:0]};
  endfunction

  // Drive one cycle of inputs, advance the model by the fetch rules, then clock.
  task automatic tick(input logic rst, input logic run, input logic redir,
                      input logic [7:0] rpc, input logic rdy);
    logic        fetch;
    logic [23:0] e;
    RESET = rst; RUN = run; REDIRECT = redir; REDIRECT_PC = rpc; INSTR_READY = rdy;
    if (rst) begin
      m_buf.delete(); m_pc = 8'h00; m_cnt = 0; m_state = M_IDLE;
    end else begin
      fetch = (m_state == M_FETCH) && run && !redir && (m_buf.size() < 2);
      if (m_buf.size() > 0 && rdy) void'(m_buf.pop_front());
      if (redir) begin
        m_buf.delete();
        m_pc = rpc & 8'hFE;
        if (m_state == M_HALT) m_state = M_FETCH;
      end else if (fetch) begin
        e = {m_pc, mem[m_pc[7:1]]};
        m_buf.push_back(e);
        if (m_cnt < 65535) m_cnt++;
        if (m_pc == 8'hFE) m_state = M_HALT;
        m_pc = m_pc + 8'd2;
      end else if (m_state == M_IDLE && run) begin
        m_state = M_FETCH;
      end else if (m_state == M_FETCH && !run) begin
        m_state = M_IDLE;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, i[0], 1'b0, 8'h00, 1'b1);
    act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
    n_checks++;
    if (act !== 50'h0) begin n_errors++; $display("FAIL reset_values: got %h expected %h", act, 50'h0); end
  endtask

  task automatic test_stream();
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (INSTR_VALID !== 1'b0) begin n_errors++; $display("FAIL stream_idle_valid: got %b expected 0", INSTR_VALID); end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 8'h00, 16'hF491}) begin
      n_errors++; $display("FAIL stream_first: got %h/%h/%h expected 1/00/f491", INSTR_VALID, INSTR_PC, INSTR);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 8'h02, 16'hF249}) begin
      n_errors++; $display("FAIL stream_second: got %h/%h/%h expected 1/02/f249", INSTR_VALID, INSTR_PC, INSTR);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
      n_checks++;
      if (act !== exp_out() || INSTR_PC !== 8'(2 * (i + 2))) begin
        n_errors++; $display("FAIL stream_cyc%0d: got %h expected %h", i, act, exp_out());
      end
    end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({IMEM_ADDR, FETCH_COUNT, INSTR} !== {8'h04, 16'd2, 16'hF491}) begin
      n_errors++; $display("FAIL stall_hold: got addr=%h cnt=%0d instr=%h expected 04/2/f491", IMEM_ADDR, FETCH_COUNT, INSTR);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_PC, INSTR, IMEM_ADDR} !== {8'h02, 16'hF249, 8'h04}) begin
      n_errors++; $display("FAIL stall_release1: got %h/%h addr=%h expected 02/f249/04", INSTR_PC, INSTR, IMEM_ADDR);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
    n_checks++;
    if (INSTR_PC !== 8'h04 || act !== exp_out()) begin
      n_errors++; $display("FAIL stall_resume: got %h expected %h", act, exp_out());
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 8'h35, 1'b0);
    n_checks++;
    if ({INSTR_VALID, IMEM_ADDR} !== {1'b0, 8'h34}) begin
      n_errors++; $display("FAIL redirect_flush: got valid=%b addr=%h expected 0/34", INSTR_VALID, IMEM_ADDR);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 8'h34, 16'h4440}) begin
      n_errors++; $display("FAIL redirect_target: got %h/%h/%h expected 1/34/4440", INSTR_VALID, INSTR_PC, INSTR);
    end
  endtask

  task automatic test_halt();
    tick(1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({HALTED, IMEM_ADDR, INSTR_PC} !== {1'b1, 8'h00, 8'hFC}) begin
      n_errors++; $display("FAIL halt_enter: got halted=%b addr=%h head=%h expected 1/00/fc", HALTED, IMEM_ADDR, INSTR_PC);
    end
    saved = FETCH_COUNT;
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (INSTR_PC !== 8'hFE) begin n_errors++; $display("FAIL halt_drain: got %h expected fe", INSTR_PC); end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, HALTED, IMEM_ADDR, FETCH_COUNT} !== {1'b0, 1'b1, 8'h00, saved}) begin
      n_errors++; $display("FAIL halt_frozen: got v=%b h=%b addr=%h cnt=%0d expected 0/1/00/%0d", INSTR_VALID, HALTED, IMEM_ADDR, FETCH_COUNT, saved);
    end
    tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    n_checks++;
    if ({HALTED, IMEM_ADDR} !== {1'b0, 8'h00}) begin
      n_errors++; $display("FAIL halt_exit: got h=%b addr=%h expected 0/00", HALTED, IMEM_ADDR);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 8'h00, 16'hF491}) begin
      n_errors++; $display("FAIL halt_restart: got %h/%h/%h expected 1/00/f491", INSTR_VALID, INSTR_PC, INSTR);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40 && m_cnt < 8; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
    n_checks++;
    if (FETCH_COUNT !== 16'd9 || act !== exp_out()) begin
      n_errors++; $display("FAIL rstmid_setup: got %h expected %h", act, exp_out());
    end
    tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
    n_checks++;
    if (act !== 50'h0) begin n_errors++; $display("FAIL rstmid_values: got %h expected %h", act, 50'h0); end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, IMEM_ADDR} !== {1'b0, 8'h00}) begin
      n_errors++; $display("FAIL rstmid_idle: got v=%b addr=%h expected 0/00", INSTR_VALID, IMEM_ADDR);
    end
  endtask

  task automatic test_run_drop();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, IMEM_ADDR, FETCH_COUNT} !== {1'b0, 8'h06, 16'd3}) begin
      n_errors++; $display("FAIL rundrop_frozen: got v=%b addr=%h cnt=%0d expected 0/06/3", INSTR_VALID, IMEM_ADDR, FETCH_COUNT);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({INSTR_VALID, INSTR_PC, INSTR} !== {1'b1, 8'h06, mem[3]}) begin
      n_errors++; $display("FAIL rundrop_resume: got %h/%h/%h expected 1/06/%h", INSTR_VALID, INSTR_PC, INSTR, mem[3]);
    end
  endtask

  task automatic test_random();
    logic       rst, run, redir, rdy;
    logic [7:0] rpc;
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      run   = ($urandom_range(0, 4) != 0);
      redir = ($urandom_range(0, 11) == 0);
      rdy   = ($urandom_range(0, 4) < 3);
      rpc   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
      tick(rst, run, redir, rpc, rdy);
      act = {INSTR_VALID, INSTR_PC, INSTR, IMEM_ADDR, HALTED, FETCH_COUNT};
      n_checks++;
      if (act !== exp_out()) begin
        n_errors++; $display("FAIL random_cyc%0d: got %h expected %h", i, act, exp_out());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'hF491;
    mem[1]  = 16'hF249;
    mem[26] = 16'h4440;
    RESET = 1'b1; RUN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 8'h00; INSTR_READY = 1'b0;
    m_pc = 8'h00; m_cnt = 0; m_state = M_IDLE;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_run_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
